term_writer: RTL and testbench

Parametrised terminal writer between the PS/2 character stream and the VRAM write port. It keeps a text cursor and interprets CR, LF and BS. It wraps lines at a configurable column count and scrolls a circular VRAM by advancing `top_row`, which feeds the HDMI scanout. It adds control-character handling, scrolling and an exported cursor position.

---
 rtl/term_pkg.sv | 29 ++
 rtl/term_wrap_inc.sv | 14 +
 rtl/term_writer.sv | 179 +++++++++++++++++
 tb/tb_term_writer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// Shared constants and state type for the terminal writer.
// The CLEAR state only exists when TERM_SCROLL_CLEAR_EN is defined.
package term_pkg;

  localparam logic [7:0] CHAR_BS       = 8'h08;
  localparam logic [7:0] CHAR_LF       = 8'h0A;
  localparam logic [7:0] CHAR_CR       = 8'h0D;
  localparam logic [7:0] CHAR_SPACE    = 8'h20;
  localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
  localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

`ifdef TERM_SCROLL_CLEAR_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUT   = 2'd1,
    ST_CLEAR = 2'd2
  } term_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUT  = 2'd1
  } term_state_t;
`endif

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CHAR_PRINT_LO) && (c <= CHAR_PRINT_HI);
  endfunction

endpackage

// File: rtl/term_wrap_inc.sv
// Modulo-N incrementer: next = (value + 1) mod N, wrap flags value == N-1.
module term_wrap_inc #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] next,
  output logic         wrap
);

  assign wrap = (value == W'(N - 1));
  assign next = wrap ? '0 : value + W'(1);

endmodule

// File: rtl/term_writer.sv
// Terminal writer: cursor, CR/LF/BS handling, line wrap and circular-VRAM scroll.
// Define TERM_SCROLL_CLEAR_EN to blank each recycled row when scrolling.
module term_writer
  import term_pkg::*;
#(
  parameter int COLS  = 100,
  parameter int ROWS  = 30,
  parameter int COL_W = $clog2(COLS),
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             reset_low,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             write_valid,
  input  logic             write_ready,
  output logic [ROW_W-1:0] write_row,
  output logic [COL_W-1:0] write_col,
  output logic [7:0]       write_char,
  output logic [ROW_W-1:0] top_row,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col
);

  localparam logic [ROW_W:0] ROWS_EXT = ROWS[ROW_W:0];

  term_state_t      state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] line_reg, line_next;
  logic [ROW_W-1:0] top_reg, top_next;
  logic [ROW_W-1:0] wr_row_reg, wr_row_next;
  logic [COL_W-1:0] wr_col_reg, wr_col_next;
  logic [7:0]       wr_char_reg, wr_char_next;
  // Set for printable writes (cursor moves on completion), clear for BS.
  logic             adv_reg, adv_next;
  logic             do_advance;

  logic [COL_W-1:0] col_inc;
  logic             col_wrap;
  logic [ROW_W-1:0] line_inc;
  logic             line_wrap;
  logic [ROW_W-1:0] top_inc;
  logic             top_wrap_unused;
  logic [ROW_W:0]   row_sum;

  term_wrap_inc #(.N(COLS), .W(COL_W)) u_col_inc (
    .value(col_reg), .next(col_inc), .wrap(col_wrap)
  );

  term_wrap_inc #(.N(ROWS), .W(ROW_W)) u_line_inc (
    .value(line_reg), .next(line_inc), .wrap(line_wrap)
  );

  term_wrap_inc #(.N(ROWS), .W(ROW_W)) u_top_inc (
    .value(top_reg), .next(top_inc), .wrap(top_wrap_unused)
  );

`ifdef TERM_SCROLL_CLEAR_EN
  logic [COL_W-1:0] clr_col_inc;
  logic             clr_wrap;

  term_wrap_inc #(.N(COLS), .W(COL_W)) u_clr_inc (
    .value(wr_col_reg), .next(clr_col_inc), .wrap(clr_wrap)
  );
`endif

  // Both operands are below ROWS, so one conditional subtract is a full mod.
  assign row_sum    = {1'b0, top_reg} + {1'b0, line_reg};
  assign cursor_row = (row_sum >= ROWS_EXT) ? ROW_W'(row_sum - ROWS_EXT)
                                            : row_sum[ROW_W-1:0];
  assign cursor_col  = col_reg;
  assign top_row     = top_reg;
  assign in_ready    = (state_reg == ST_IDLE);
  assign write_valid = (state_reg != ST_IDLE);
  assign write_row   = wr_row_reg;
  assign write_col   = wr_col_reg;
  assign write_char  = wr_char_reg;

  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    line_next    = line_reg;
    top_next     = top_reg;
    wr_row_next  = wr_row_reg;
    wr_col_next  = wr_col_reg;
    wr_char_next = wr_char_reg;
    adv_next     = adv_reg;
    do_advance   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_printable(in_char)) begin
            state_next   = ST_PUT;
            wr_row_next  = cursor_row;
            wr_col_next  = col_reg;
            wr_char_next = in_char;
            adv_next     = 1'b1;
          end else if (in_char == CHAR_CR) begin
            col_next = '0;
          end else if (in_char == CHAR_LF) begin
            do_advance = 1'b1;
          end else if ((in_char == CHAR_BS) && (col_reg != '0)) begin
            state_next   = ST_PUT;
            col_next     = col_reg - COL_W'(1);
            wr_row_next  = cursor_row;
            wr_col_next  = col_reg - COL_W'(1);
            wr_char_next = CHAR_SPACE;
            adv_next     = 1'b0;
          end
        end
      end

      ST_PUT: begin
        if (write_ready) begin
          state_next = ST_IDLE;
          if (adv_reg) begin
            col_next   = col_inc;
            do_advance = col_wrap;
          end
        end
      end

`ifdef TERM_SCROLL_CLEAR_EN
      ST_CLEAR: begin
        if (write_ready) begin
          if (clr_wrap) begin
            state_next = ST_IDLE;
          end else begin
            wr_col_next = clr_col_inc;
          end
        end
      end
`endif

      default: state_next = ST_IDLE;
    endcase

    // Line advance; at the bottom line the screen scrolls instead.
    if (do_advance) begin
      if (!line_wrap) begin
        line_next = line_inc;
      end else begin
        top_next = top_inc;
`ifdef TERM_SCROLL_CLEAR_EN
        // The cursor lands on the row that was on top before the scroll.
        state_next   = ST_CLEAR;
        wr_row_next  = top_reg;
        wr_col_next  = '0;
        wr_char_next = CHAR_SPACE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state_reg   <= ST_IDLE;
      col_reg     <= '0;
      line_reg    <= '0;
      top_reg     <= '0;
      wr_row_reg  <= '0;
      wr_col_reg  <= '0;
      wr_char_reg <= '0;
      adv_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_reg     <= col_next;
      line_reg    <= line_next;
      top_reg     <= top_next;
      wr_row_reg  <= wr_row_next;
      wr_col_reg  <= wr_col_next;
      wr_char_reg <= wr_char_next;
      adv_reg     <= adv_next;
    end
  end

endmodule

// File: tb/tb_term_writer.sv
// Self-checking bench for term_writer: directed scenarios plus a random soak
// scored against a cursor/screen model and an expected-write queue.
module tb_term_writer;

  localparam int COLS  = 100;
  localparam int ROWS  = 30;
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic             clk = 1'b0;
  logic             reset_low = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_char = 8'h00;
  logic             write_valid;
  logic             write_ready = 1'b0;
  logic [ROW_W-1:0] write_row;
  logic [COL_W-1:0] write_col;
  logic [7:0]       write_char;
  logic [ROW_W-1:0] top_row;
  logic [ROW_W-1:0] cursor_row;
  logic [COL_W-1:0] cursor_col;

  always #5 clk = ~clk;

  term_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset_low(reset_low),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_row(write_row), .write_col(write_col), .write_char(write_char),
    .top_row(top_row), .cursor_row(cursor_row), .cursor_col(cursor_col)
  );

  typedef struct {
    int row;
    int col;
    int ch;
  } wr_t;

  int  vectors = 0;
  int  miscompares = 0;
  int  m_col = 0, m_line = 0, m_top = 0;
  wr_t exp_q[$];
  int  writes_seen = 0;
  int  rdy_mode = 1;  // 0 = held low, 1 = held high, 2 = random

`ifdef TERM_SCROLL_CLEAR_EN
  localparam int SCROLL_WRITES = COLS;
`else
  localparam int SCROLL_WRITES = 0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int phys_row();
    return (m_top + m_line) % ROWS;
  endfunction

  task automatic m_advance();
    if (m_line < ROWS - 1) begin
      m_line++;
    end else begin
      m_top = (m_top + 1) % ROWS;
      for (int c = 0; c < SCROLL_WRITES; c++) exp_q.push_back('{phys_row(), c, 32'h20});
    end
  endtask

  task automatic m_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_q.push_back('{phys_row(), m_col, int'(ch)});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        m_advance();
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_advance();
    end else if (ch == 8'h08 && m_col > 0) begin
      m_col--;
      exp_q.push_back('{phys_row(), m_col, 32'h20});
    end
  endtask

  // One clock: score a completing write, advance, then check the invariants.
  task automatic step();
    if (reset_low && write_valid && write_ready) begin
      writes_seen++;
      if (exp_q.size() == 0) begin
        chk("spurious_write", write_valid, 1'b0);
      end else begin
        wr_t e = exp_q.pop_front();
        chk("write_row", write_row, e.row);
        chk("write_col", write_col, e.col);
        chk("write_char", write_char, e.ch);
      end
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       write_ready = 1'b0;
      1:       write_ready = 1'b1;
      default: write_ready = 1'($urandom_range(0, 1));
    endcase
    if (reset_low) begin
      chk("in_ready", in_ready, exp_q.size() == 0);
      chk("write_valid", write_valid, exp_q.size() != 0);
      if (exp_q.size() == 0) begin
        chk("cursor_col", cursor_col, m_col);
        chk("cursor_row", cursor_row, phys_row());
        chk("top_row", top_row, m_top);
      end
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int  n = 0;
    bit  acc = 1'b0;
    in_valid = 1'b1;
    in_char  = ch;
    while (!acc) begin
      acc = in_ready;
      if (acc) m_char(ch);
      step();
      n++;
      if (!acc && n > 2000) begin
        chk("accept_timeout", in_ready, 1'b1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_low = 1'b0;
    in_valid  = 1'b0;
    #1;
    exp_q.delete();
    m_col  = 0;
    m_line = 0;
    m_top  = 0;
    chk("rst_write_valid", write_valid, 1'b0);
    chk("rst_write_row", write_row, 0);
    chk("rst_write_col", write_col, 0);
    chk("rst_write_char", write_char, 0);
    chk("rst_top_row", top_row, 0);
    chk("rst_cursor_row", cursor_row, 0);
    chk("rst_cursor_col", cursor_col, 0);
    chk("rst_in_ready", in_ready, 1'b1);
    step();
    step();
    reset_low = 1'b1;
  endtask

  initial begin
    int   w0;
    logic [ROW_W-1:0] s_row;
    logic [COL_W-1:0] s_col;
    logic [7:0]       s_char;
    logic [7:0]       c;

    // Single printable with write_ready tied high
    rdy_mode = 1;
    write_ready = 1'b1;
    do_reset();
    send(8'h41);
    chk("A_write_valid", write_valid, 1'b1);
    chk("A_write_row", write_row, 0);
    chk("A_write_col", write_col, 0);
    chk("A_write_char", write_char, 8'h41);
    chk("A_in_ready_busy", in_ready, 1'b0);
    step();
    chk("A_cursor_col", cursor_col, 1);
    chk("A_in_ready_back", in_ready, 1'b1);

    // Full line of printables, then wrap onto the next line
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < COLS; i++) send(8'($urandom_range(32'h20, 32'h7E)));
    send(8'h42);
    drain();
    chk("wrap_top_row", top_row, 0);
    chk("wrap_cursor_row", cursor_row, 1);
    chk("wrap_cursor_col", cursor_col, 1);

    // Backspace, including the no-op at column 0
    do_reset();
    rdy_mode = 1;
    send(8'h58);
    send(8'h59);
    send(8'h08);
    send(8'h08);
    drain();
    w0 = writes_seen;
    send(8'h08);
    step();
    chk("bs_col0_no_write", writes_seen - w0, 0);
    chk("bs_cursor_col", cursor_col, 0);

    // ROWS line feeds from reset force exactly one scroll
    do_reset();
    w0 = writes_seen;
    for (int i = 0; i < ROWS; i++) send(8'h0A);
    drain();
    chk("lf_top_row", top_row, 1);
    chk("lf_cursor_row", cursor_row, 0);
    chk("lf_write_count", writes_seen - w0, SCROLL_WRITES);

    // Stall a pending write, then reset in the middle of the stall
    do_reset();
    rdy_mode = 0;
    write_ready = 1'b0;
    send(8'h51);
    s_row  = write_row;
    s_col  = write_col;
    s_char = write_char;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_write_row", write_row, s_row);
      chk("stall_write_col", write_col, s_col);
      chk("stall_write_char", write_char, s_char);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    do_reset();
    rdy_mode = 1;

    // Ignored codes and CR interleaved: one accept per cycle, no writes
    do_reset();
    rdy_mode = 2;
    w0 = writes_seen;
    for (int i = 0; i < 40; i++) send((i % 2 == 0) ? 8'h07 : 8'h0D);
    chk("ctl_no_writes", writes_seen - w0, 0);
    chk("ctl_cursor_col", cursor_col, 0);

    // Random soak: text, CR, LF, BS and junk with random write_ready
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 700; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: c = 8'($urandom_range(32'h20, 32'h7E));
        4, 5:       c = 8'h0A;
        6:          c = 8'h0D;
        7:          c = 8'h08;
        8:          c = 8'($urandom_range(0, 31));
        default:    c = 8'($urandom_range(32'h7F, 32'hFF));
      endcase
      send(c);
    end
    drain();
    chk("soak_top_row", top_row, m_top);
    chk("soak_cursor_col", cursor_col, m_col);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
